// File: rtl/seq_divider_if.sv
// Div handshake between the ALU (master) and the sequential divider (slave).
// Optional divide-by-zero flag present when SEQ_DIVIDER_BYZERO_FLAG_EN is defined.
interface seq_divider_if #(
  parameter int DATA_W = 32
);
  // start_i is held by the master until ready_o is seen; result_o is valid while ready_o=1.
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
  logic                  divbyzero_o;
`endif

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
    input  divbyzero_o,
`endif
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
    output divbyzero_o,
`endif
    output result_o, ready_o
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle; returns {remainder, quotient}.
// Optional divbyzero_o output enabled by SEQ_DIVIDER_BYZERO_FLAG_EN.
module seq_divider #(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  seq_divider_if.slave     div,
  output logic [1:0]       o_dbg_state
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]     r_divisor;
  logic                  r_qneg;
  logic                  r_rneg;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
  logic                  r_zero;
  logic                  r_divbyzero;
`endif

  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic [DATA_W:0]       w_trial;
  logic [DATA_W-1:0]     w_diff;
  logic                  w_ge;
  logic [2*DATA_W-1:0]   w_next;
  logic [DATA_W-1:0]     w_rem;
  logic [DATA_W-1:0]     w_quo;
  logic [2*DATA_W-1:0]   w_final;
  logic                  w_last;

  // r_dividend holds {partial remainder, dividend/quotient}; quotient bits enter at the LSB.
  always_comb begin
    w_abs_a = (div.signed_div_i && div.opdata1_i[DATA_W-1]) ? -div.opdata1_i : div.opdata1_i;
    w_abs_b = (div.signed_div_i && div.opdata2_i[DATA_W-1]) ? -div.opdata2_i : div.opdata2_i;
    w_trial = r_dividend[2*DATA_W-1:DATA_W-1];
    w_ge    = (w_trial >= {1'b0, r_divisor});
    w_diff  = w_trial[DATA_W-1:0] - r_divisor;
    if (w_ge) w_next = {w_diff, r_dividend[DATA_W-2:0], 1'b1};
    else      w_next = {r_dividend[2*DATA_W-2:0], 1'b0};
    w_rem   = w_next[2*DATA_W-1:DATA_W];
    w_quo   = w_next[DATA_W-1:0];
    w_final = {(r_rneg ? -w_rem : w_rem), (r_qneg ? -w_quo : w_quo)};
    w_last  = (r_cnt == CNT_W'(DATA_W-1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
      r_zero      <= 1'b0;
      r_divbyzero <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (div.start_i && !div.annul_i) begin
            if (div.opdata2_i == '0) begin
              r_state <= S_BYZERO;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
              r_zero  <= 1'b1;
`endif
            end else begin
              r_state    <= S_ON;
              r_dividend <= {{DATA_W{1'b0}}, w_abs_a};
              r_divisor  <= w_abs_b;
              r_qneg     <= div.signed_div_i & (div.opdata1_i[DATA_W-1] ^ div.opdata2_i[DATA_W-1]);
              r_rneg     <= div.signed_div_i & div.opdata1_i[DATA_W-1];
              r_cnt      <= '0;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
              r_zero     <= 1'b0;
`endif
            end
          end
        end
        S_BYZERO: begin
          r_dividend <= '0;
          r_state    <= S_END;
        end
        S_ON: begin
          if (div.annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_dividend <= w_final;
              r_state    <= S_END;
            end else begin
              r_dividend <= w_next;
            end
          end
        end
        S_END: begin
          // Result stays in r_dividend, so re-copying it while leaving keeps result_o steady.
          r_result <= r_dividend;
          if (div.start_i) begin
            r_ready <= 1'b1;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
            r_divbyzero <= r_zero;
`endif
          end else begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
            r_divbyzero <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div.result_o = r_result;
  assign div.ready_o  = r_ready;
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
  assign div.divbyzero_o = r_divbyzero;
`endif
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus annul and mid-division reset sequences.
module tb_seq_divider;
  logic       clk;
  logic       rst;
  logic [1:0] o_dbg_state;

  seq_divider_if #(.DATA_W(32)) dif ();

  seq_divider #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .div         (dif.slave),
    .o_dbg_state (o_dbg_state)
  );

  typedef struct {
    string       name;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd2;

  int          total;
  int          bad;
  logic [63:0] exp_q[$];
  logic [63:0] last_result;
  vec_t        vecs[14];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int          cyc;
    logic        seen;
    logic [63:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    dif.signed_div_i = sg;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dif.ready_o) seen = 1'b1;
    end
    want = exp_q.pop_front();
    check({name, " ready seen"}, 64'(seen), 64'(1));
    check({name, " latency"}, 64'(cyc - 1), 64'(exp_lat));
    check({name, " result"}, dif.result_o, want);
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
    check({name, " divbyzero"}, 64'(dif.divbyzero_o), 64'(b == 32'd0));
`endif
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " ready drop"}, 64'(dif.ready_o), 64'(0));
    check({name, " result hold"}, dif.result_o, want);
    check({name, " back idle"}, 64'(o_dbg_state), 64'(ST_IDLE));
    last_result = want;
  endtask

  task automatic watch_no_ready(input string name, input int cycles);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (dif.ready_o) hit = 1'b1;
    end
    check(name, 64'(hit), 64'(0));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_result = '0;
    vecs[0]  = '{"u100/7",      1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                 33};
    vecs[1]  = '{"s-7/2",       1'b1, 32'hFFFFFFF9,  32'h00000002,  {32'hFFFFFFFF, 32'hFFFFFFFD},    33};
    vecs[2]  = '{"s7/-2",       1'b1, 32'h00000007,  32'hFFFFFFFE,  {32'h00000001, 32'hFFFFFFFD},    33};
    vecs[3]  = '{"s_minint/-1", 1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000},           33};
    vecs[4]  = '{"u_max/1",     1'b0, 32'hFFFFFFFF,  32'h00000001,  {32'h0, 32'hFFFFFFFF},           33};
    vecs[5]  = '{"u5/0",        1'b0, 32'd5,         32'd0,         64'h0,                           2};
    vecs[6]  = '{"s-5/0",       1'b1, 32'hFFFFFFFB,  32'd0,         64'h0,                           2};
    vecs[7]  = '{"u9/3",        1'b0, 32'd9,         32'd3,         {32'd0, 32'd3},                  33};
    vecs[8]  = '{"s-100/7",     1'b1, 32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE, 32'hFFFFFFF2},    33};
    vecs[9]  = '{"u_minint/max",1'b0, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000, 32'h0},           33};
    vecs[10] = '{"s-8/-3",      1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD,  {32'hFFFFFFFE, 32'h00000002},    33};
    vecs[11] = '{"u12345678/1000", 1'b0, 32'd12345678, 32'd1000,    {32'h000002A6, 32'h00003039},    33};
    vecs[12] = '{"u0/5",        1'b0, 32'd0,         32'd5,         64'h0,                           33};
    vecs[13] = '{"u-7/2",       1'b0, 32'hFFFFFFF9,  32'd2,         {32'h00000001, 32'h7FFFFFFC},    33};

    rst              = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", dif.result_o, 64'h0);
    check("reset ready", 64'(dif.ready_o), 64'(0));
    check("reset state", 64'(o_dbg_state), 64'(ST_IDLE));
`ifdef SEQ_DIVIDER_BYZERO_FLAG_EN
    check("reset divbyzero", 64'(dif.divbyzero_o), 64'(0));
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++)
      run_div(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // annul mid-division, then annul racing a fresh start in IDLE
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("annul busy", 64'(o_dbg_state), 64'(ST_ON));
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul to idle", 64'(o_dbg_state), 64'(ST_IDLE));
    check("annul result", dif.result_o, last_result);
    @(posedge clk);
    #1;
    check("annul beats start", 64'(o_dbg_state), 64'(ST_IDLE));
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    watch_no_ready("annul no ready", 40);
    run_div("after annul u9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // synchronous reset pulse during a division
    @(negedge clk);
    dif.signed_div_i = 1'b1;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst result", dif.result_o, 64'h0);
    check("midrst ready", 64'(dif.ready_o), 64'(0));
    check("midrst state", 64'(o_dbg_state), 64'(ST_IDLE));
    rst         = 1'b1;
    dif.start_i = 1'b0;
    watch_no_ready("midrst no ready", 40);
    run_div("after rst u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider; the responder side of the ALU's div start/ready handshake.
- The ALU drives operands, the sign select and start; this block returns {remainder, quotient} as a 64-bit HILO value plus a ready strobe.
- Used for MIPS DIV/DIVU; the result is written to HI (remainder) and LO (quotient).

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W; result width is 2*DATA_W.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 resets on clk edge)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
opdata1_i  input  DATA_W  dividend (rs)
opdata2_i  input  DATA_W  divisor (rt)
start_i  input  1  request; ALU holds high until ready observed
annul_i  input  1  abort in-flight division (exception/flush)
result_o  output  2*DATA_W  {remainder, quotient}
ready_o  output  1  result valid

Behaviour:
- Reset (rst==0 at edge, any state): state=IDLE, result_o=0, ready_o=0, internal counter and dividend registers=0. Reset mid-division discards all work.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. Latch sign select and the absolute values of the operands (absolute value only if signed and MSB=1, else raw). Latch the quotient/remainder negate flags: qneg = a[MSB]^b[MSB], rneg = a[MSB], both only when signed. Counter=0.
  - Otherwise stay in IDLE.
  - ready_o=0; result_o holds its last value.
- BYZERO: next cycle -> END with result 0 (quotient 0, remainder 0).
- ON: one restoring step per cycle.
  - Shift the {partial remainder, dividend} register left 1.
  - Trial-subtract the divisor from the upper DATA_W+1 bits.
  - If non-negative, keep the difference and shift in 1; else shift in 0.
  - Counter increments.
  - After DATA_W steps (counter==DATA_W-1 on the step), apply negation: quotient negated if qneg, remainder negated if rneg (two's complement). Go to END.
  - annul_i=1 in ON -> IDLE next cycle; ready_o stays 0; result_o unchanged.
  - start_i changes in ON are ignored; operands are already latched.
- END: result_o registered as {rem, quo}; ready_o=1.
  - Stay in END while start_i=1.
  - start_i=0 -> IDLE; ready_o=0 next cycle; result_o held.
  - With the ALU gating start with ~ready, ready_o is high exactly 1 cycle.
- Latency: start sampled at edge T0. ready_o high after edge T0+DATA_W+1 (33 cycles for DATA_W=32). Divide-by-zero: ready_o high after T0+2.
- Arithmetic:
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0, no trap.
  - Unsigned: plain 32-bit division.
- Simultaneous start_i and annul_i in IDLE: annul wins, stay in IDLE.
- Back-to-back requests: a new start is accepted only from IDLE, i.e. at least 1 idle cycle after END.

Optional Feature:
- Macro: SEQ_DIVIDER_BYZERO_FLAG_EN.
- Defined: adds output divbyzero_o (1 bit), reset 0.
  - Set to 1 together with ready_o when the division came through BYZERO.
  - Cleared when leaving END.
  - Supports a future divide-by-zero exception in the ALU.
- Undefined: the port is absent. Divide-by-zero still returns 0 via BYZERO with no indication.

Test Plan:
1. Unsigned 100 / 7, start held until ready -> ready_o after 33 cycles; result_o = {32'd2, 32'd14}; ready_o high 1 cycle; result_o held afterwards.
2. Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 7 / -2 -> {32'h00000001, 32'hFFFFFFFD}.
3. Signed 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}. Unsigned 0xFFFFFFFF / 1 -> {32'h0, 32'hFFFFFFFF}.
4. Divisor 0 (5 / 0) -> ready_o 2 cycles after start, result_o = 64'h0. With SEQ_DIVIDER_BYZERO_FLAG_EN, divbyzero_o=1 coincident with ready_o.
5. Start 100/7, assert annul_i at cycle 10 -> IDLE, no ready_o. Then a new 9/3 request -> {0, 3} after 33 cycles.
6. rst=0 for 1 cycle at cycle 15 of a division -> result_o=0 and ready_o=0 next edge; ready_o never asserts for the aborted request.
